cpu_icache_dm: RTL and testbench
================================

CPU_ICACHE_DM -- requirements
Module: cpu_icache_dm

Interface
REQ-001 Parameter LINE_WORDS, default 4, 32-bit words per cache line; power of two, 2..16.
REQ-002 Parameter NUM_LINES, default 64, number of direct-mapped lines; power of two, 4..1024.
REQ-003 clock  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 cpui_request  input  1  CPU fetch request, one-cycle pulse.
REQ-006 cpui_addr  input  32  fetch byte address, word aligned; bits [1:0] ignored.
REQ-007 cpui_rdata  output  32  fetched instruction; 0 whenever cpui_ack is 0.
REQ-008 cpui_ack  output  1  one-cycle pulse, fetch complete.
REQ-009 invalidate  input  1  one-cycle pulse, invalidate the whole cache.
REQ-010 mem_request  output  1  level; held high for the duration of a line refill.
REQ-011 mem_addr  output  32  word address currently requested from the backing memory.
REQ-012 mem_rdata  input  32  refill data; valid when mem_ack is 1.
REQ-013 mem_ack  input  1  one pulse per word returned.
REQ-014 busy  output  1  high in REFILL, RESPOND and FLUSH states.

Function
REQ-015 Address split: offset = addr[2 +: log2(LINE_WORDS)]; index = next log2(NUM_LINES) bits; tag = remaining upper bits.
REQ-016 Storage: data array NUM_LINES*LINE_WORDS x 32, tag array, valid bit per line.
REQ-017 States: IDLE, REFILL, RESPOND, FLUSH.
REQ-018 IDLE: a request in cycle N is captured, and tag/valid compared in cycle N+1.
REQ-019 Hit: cpui_ack=1 and cpui_rdata=word in cycle N+1; state stays IDLE.
REQ-020 Back-to-back: a request in the same cycle as a hit ack is accepted, giving one fetch per cycle on consecutive hits.
REQ-021 Miss: no ack in cycle N+1; state goes to REFILL.
REQ-022 REFILL: mem_request=1; mem_addr = line base + 4*word counter, counter starting at 0.
REQ-023 REFILL data handling: each mem_ack writes mem_rdata into the line and increments the counter.
REQ-024 REFILL completion: on the LINE_WORDS-th mem_ack, tag is written, valid is set, mem_request drops in the next cycle, and state goes to RESPOND.
REQ-025 RESPOND: cpui_ack=1 for one cycle with the requested word, then IDLE.
REQ-026 Miss latency with zero-wait memory: ack LINE_WORDS+2 cycles after the request cycle.
REQ-027 mem_ack outside REFILL is ignored.
REQ-028 cpui_request while busy=1 and not in FLUSH is a protocol violation; it is ignored.
REQ-029 invalidate in IDLE with no request pending: FLUSH next cycle.
REQ-030 invalidate at any other time, or coincident with a request: latched and taken immediately after the current fetch acks.
REQ-031 FLUSH: clears one valid bit per cycle, index 0..NUM_LINES-1, lasting NUM_LINES cycles, then IDLE.
REQ-032 A request arriving during FLUSH is latched and serviced after FLUSH as a lookup; it always misses.
REQ-033 A second invalidate during FLUSH is absorbed; the flush is not restarted.

Reset
REQ-034 reset low asynchronously forces IDLE; cpui_ack=0, cpui_rdata=0, mem_request=0, mem_addr=0, busy=0.
REQ-035 reset low also clears all valid bits, the pending invalidate and the pending request; data and tag arrays are not cleared.
REQ-036 Reset asserted mid-REFILL or mid-FLUSH aborts the operation; no partial line is left valid.

Configuration
REQ-037 Macro ICACHE_STATS_EN defined: outputs hit_count and miss_count, 32 bits each, reset to 0.
REQ-038 With ICACHE_STATS_EN, the counters increment on each hit and each miss decision, wrap modulo 2^32, and are cleared by invalidate.
REQ-039 Macro ICACHE_STATS_EN undefined: neither port nor counters exist; all other behaviour is identical.

Verification
REQ-040 Cold fetch 0x100, defaults, zero-wait memory -> mem_addr 0x100,0x104,0x108,0x10C; ack with the word at 0x100 at cycle +6.
REQ-041 Fetches 0x104, 0x108, 0x10C on consecutive cycles after the REFILL-040 line fill -> acks on three consecutive cycles; mem_request stays 0.
REQ-042 Fetch 0x100 then 0x1100 (same index, different tag), then 0x100 again -> three refills occur; returned data is correct for each address.
REQ-043 invalidate during REFILL of 0x200 -> fetch acks; FLUSH lasts 64 cycles with busy=1; a refetch of 0x200 misses.
REQ-044 reset low for one cycle mid-REFILL after 2 of 4 words -> mem_request falls immediately; a later fetch of the same line misses.
REQ-045 With ICACHE_STATS_EN: 1 miss then 3 hits -> hit_count=3, miss_count=1; after invalidate, both counters read 0.

Source files
------------

// File: rtl/cpu_icache_dm.sv
// cpu_icache_dm: direct-mapped instruction cache with word-by-word line refill and a sequential whole-cache flush.
// Define ICACHE_STATS_EN to add the hit_count/miss_count statistics outputs.
module cpu_icache_dm #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned NUM_LINES  = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        cpui_request,
    input  logic [31:0] cpui_addr,
    output logic [31:0] cpui_rdata,
    output logic        cpui_ack,
    input  logic        invalidate,
    output logic        mem_request,
    output logic [31:0] mem_addr,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        busy
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int unsigned OFF_W = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W = $clog2(NUM_LINES);
    localparam int unsigned TAG_W = 30 - OFF_W - IDX_W;
    localparam int unsigned DEPTH = NUM_LINES * LINE_WORDS;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESPOND, S_FLUSH} state_e;

    state_e                 state_q, state_d;
    logic                   req_pend_q, req_pend_d;
    logic [29:0]            req_addr_q, req_addr_d;
    logic [OFF_W-1:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0]       flush_idx_q, flush_idx_d;
    logic                   pend_inv_q, pend_inv_d;
    logic                   ack_q, ack_d;
    logic [31:0]            rdata_q, rdata_d;
    logic                   mreq_q, mreq_d;
    logic [31:0]            maddr_q, maddr_d;
    logic                   busy_q, busy_d;
    logic [NUM_LINES-1:0]   valid_q, valid_d;

    logic [31:0]            data_mem [DEPTH];
    logic [TAG_W-1:0]       tag_mem  [NUM_LINES];

    logic                   look_req, look_hit, flush_go;
    logic [29:0]            look_addr;
    logic [IDX_W-1:0]       look_idx, ref_idx;
    logic [OFF_W-1:0]       look_off, ref_off;
    logic [TAG_W-1:0]       look_tag, ref_tag;
    logic                   data_we, tag_we, hit_inc, miss_inc;
    logic                   unused_addr;

    // A request latched during a flush takes precedence over the live request port.
    assign look_req    = req_pend_q | cpui_request;
    assign look_addr   = req_pend_q ? req_addr_q : cpui_addr[31:2];
    assign look_off    = look_addr[OFF_W-1:0];
    assign look_idx    = look_addr[OFF_W +: IDX_W];
    assign look_tag    = look_addr[29 -: TAG_W];
    assign look_hit    = valid_q[look_idx] && (tag_mem[look_idx] == look_tag);
    assign ref_off     = req_addr_q[OFF_W-1:0];
    assign ref_idx     = req_addr_q[OFF_W +: IDX_W];
    assign ref_tag     = req_addr_q[29 -: TAG_W];
    assign unused_addr = ^cpui_addr[1:0];

    always_comb begin
        state_d     = state_q;
        req_pend_d  = req_pend_q;
        req_addr_d  = req_addr_q;
        cnt_d       = cnt_q;
        flush_idx_d = flush_idx_q;
        pend_inv_d  = pend_inv_q;
        ack_d       = 1'b0;
        rdata_d     = '0;
        mreq_d      = mreq_q;
        maddr_d     = maddr_q;
        valid_d     = valid_q;
        data_we     = 1'b0;
        tag_we      = 1'b0;
        hit_inc     = 1'b0;
        miss_inc    = 1'b0;
        flush_go    = invalidate | pend_inv_q;

        case (state_q)
            S_IDLE: begin
                if (look_req) begin
                    req_pend_d = 1'b0;
                    req_addr_d = look_addr;
                    if (look_hit) begin
                        hit_inc     = 1'b1;
                        ack_d       = 1'b1;
                        rdata_d     = data_mem[{look_idx, look_off}];
                        pend_inv_d  = 1'b0;
                        flush_idx_d = '0;
                        state_d     = flush_go ? S_FLUSH : S_IDLE;
                    end else begin
                        // The victim line is dropped up front so an aborted refill never leaves it valid.
                        miss_inc          = 1'b1;
                        valid_d[look_idx] = 1'b0;
                        pend_inv_d        = flush_go;
                        cnt_d             = '0;
                        mreq_d            = 1'b1;
                        maddr_d           = {look_addr[29:OFF_W], {OFF_W{1'b0}}, 2'b00};
                        state_d           = S_REFILL;
                    end
                end else if (flush_go) begin
                    pend_inv_d  = 1'b0;
                    flush_idx_d = '0;
                    state_d     = S_FLUSH;
                end
            end
            S_REFILL: begin
                if (invalidate) pend_inv_d = 1'b1;
                if (mem_ack) begin
                    data_we = 1'b1;
                    cnt_d   = cnt_q + OFF_W'(1);
                    maddr_d = maddr_q + 32'd4;
                    if (cnt_q == OFF_W'(LINE_WORDS - 1)) begin
                        tag_we           = 1'b1;
                        valid_d[ref_idx] = 1'b1;
                        mreq_d           = 1'b0;
                        state_d          = S_RESPOND;
                    end
                end
            end
            S_RESPOND: begin
                ack_d      = 1'b1;
                rdata_d    = data_mem[{ref_idx, ref_off}];
                pend_inv_d = 1'b0;
                flush_idx_d = '0;
                state_d    = flush_go ? S_FLUSH : S_IDLE;
            end
            S_FLUSH: begin
                valid_d[flush_idx_q] = 1'b0;
                flush_idx_d          = flush_idx_q + IDX_W'(1);
                if (cpui_request && !req_pend_q) begin
                    req_pend_d = 1'b1;
                    req_addr_d = cpui_addr[31:2];
                end
                if (flush_idx_q == IDX_W'(NUM_LINES - 1)) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            req_pend_q  <= 1'b0;
            req_addr_q  <= '0;
            cnt_q       <= '0;
            flush_idx_q <= '0;
            pend_inv_q  <= 1'b0;
            ack_q       <= 1'b0;
            rdata_q     <= '0;
            mreq_q      <= 1'b0;
            maddr_q     <= '0;
            busy_q      <= 1'b0;
            valid_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_pend_q  <= req_pend_d;
            req_addr_q  <= req_addr_d;
            cnt_q       <= cnt_d;
            flush_idx_q <= flush_idx_d;
            pend_inv_q  <= pend_inv_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
            mreq_q      <= mreq_d;
            maddr_q     <= maddr_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
        end
    end

    // Data and tag storage carry no reset; the valid bits alone gate their use.
    always_ff @(posedge clock) begin
        if (data_we) data_mem[{ref_idx, cnt_q}] <= mem_rdata;
        if (tag_we)  tag_mem[ref_idx]           <= ref_tag;
    end

    assign cpui_ack    = ack_q;
    assign cpui_rdata  = rdata_q;
    assign mem_request = mreq_q;
    assign mem_addr    = maddr_q;
    assign busy        = busy_q;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else if (invalidate) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_inc)  hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (miss_inc) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = hit_inc | miss_inc;
`endif

endmodule

// File: tb/tb_cpu_icache_dm.sv
// tb_cpu_icache_dm: scoreboard bench for cpu_icache_dm; backing memory returns a hash of each word address,
// and a line-level tag/valid model predicts hits, misses and the refill address sequence.
module tb_cpu_icache_dm;

    localparam int unsigned LW = 4;
    localparam int unsigned NL = 64;

    logic        clock = 1'b0;
    logic        rst_n = 1'b1;
    logic        cpui_request = 1'b0;
    logic [31:0] cpui_addr = '0;
    logic        invalidate = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic [31:0] cpui_rdata, mem_addr;
    logic        cpui_ack, mem_request, busy;
`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    cpu_icache_dm #(.LINE_WORDS(LW), .NUM_LINES(NL)) dut (
        .clock(clock), .reset(rst_n),
        .cpui_request(cpui_request), .cpui_addr(cpui_addr),
        .cpui_rdata(cpui_rdata), .cpui_ack(cpui_ack),
        .invalidate(invalidate),
        .mem_request(mem_request), .mem_addr(mem_addr),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .busy(busy)
`ifdef ICACHE_STATS_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    initial forever #5 clock = ~clock;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] maddr_q[$];
    bit          m_valid[NL];
    logic [31:0] m_tag[NL];
    bit          zero_wait = 1'b1;
    int          ack_budget = -1;

    task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    // Returns 1 on a predicted hit; on a miss installs the line and queues its refill addresses.
    function automatic bit model_access(input logic [31:0] a);
        int unsigned line_bytes = LW * 4;
        int unsigned idx  = (a / line_bytes) % NL;
        logic [31:0] tag  = a / (line_bytes * NL);
        logic [31:0] base = a - (a % line_bytes);
        if (m_valid[idx] && m_tag[idx] == tag) return 1'b1;
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        for (int k = 0; k < int'(LW); k++) maddr_q.push_back(base + 32'(4 * k));
        return 1'b0;
    endfunction

    function automatic void model_invalidate();
        for (int i = 0; i < int'(NL); i++) m_valid[i] = 1'b0;
    endfunction

    // Ack monitor: every ack pops one expected word; rdata must read zero otherwise.
    initial forever begin
        logic [31:0] e;
        @(negedge clock);
        if (cpui_ack) begin
            if (exp_q.size() == 0) chk(1'b0, "unexpected_ack", cpui_rdata, 32'h0);
            else begin
                e = exp_q.pop_front();
                chk(cpui_rdata == e, "ack_rdata", cpui_rdata, e);
            end
        end else begin
            chk(cpui_rdata == 32'h0, "rdata_zero_without_ack", cpui_rdata, 32'h0);
        end
    end

    // Backing memory: optional wait states, stray acks while idle, refill address checking.
    initial forever begin
        logic [31:0] ea;
        @(negedge clock);
        if (mem_request && ack_budget != 0 && (zero_wait || $urandom_range(0, 2) != 0)) begin
            mem_ack   = 1'b1;
            mem_rdata = mem_word(mem_addr);
            if (ack_budget > 0) ack_budget--;
            if (maddr_q.size() == 0) chk(1'b0, "unexpected_refill", mem_addr, 32'h0);
            else begin
                ea = maddr_q.pop_front();
                chk(mem_addr == ea, "mem_addr", mem_addr, ea);
            end
        end else begin
            mem_ack   = !mem_request && ($urandom_range(0, 7) == 0);
            mem_rdata = $urandom;
        end
    end

    task automatic count_flush(input string name);
        int bc = 0;
        while (busy && bc < 400) begin
            bc++;
            @(negedge clock);
        end
        chk(bc == int'(NL), name, 32'(bc), 32'(NL));
    endtask

    // inv_at: -1 none, 0 with the request, k>0 driven k cycles after the request.
    task automatic fetch(input logic [31:0] a, input int inv_at, output bit hit);
        int lat = 0;
        hit = model_access(a);
        exp_q.push_back(mem_word(a & ~32'h3));
        @(negedge clock);
        cpui_request = 1'b1;
        cpui_addr    = a;
        invalidate   = (inv_at == 0);
        do begin
            @(negedge clock);
            lat++;
            cpui_request = 1'b0;
            invalidate   = (lat == inv_at);
        end while (!cpui_ack && lat < 400);
        invalidate = 1'b0;
        if (!cpui_ack)      chk(1'b0, "ack_timeout", 32'(lat), 32'(LW + 2));
        else if (hit)       chk(lat == 1, "hit_latency", 32'(lat), 32'd1);
        else if (zero_wait) chk(lat == int'(LW + 2), "miss_latency", 32'(lat), 32'(LW + 2));
        else                chk(lat >= int'(LW + 2), "miss_latency_min", 32'(lat), 32'(LW + 2));
        if (inv_at >= 0) begin
            model_invalidate();
            count_flush("flush_after_fetch");
        end
    endtask

    task automatic do_flush();
        @(negedge clock);
        invalidate = 1'b1;
        @(negedge clock);
        invalidate = 1'b0;
        model_invalidate();
        count_flush("flush_idle");
    endtask

    initial begin
        bit          h;
        int          bc, lat, acks;
        bit          mreq_seen;
        logic [31:0] a;

        #1 rst_n = 1'b0;
        repeat (3) @(negedge clock);
        chk(cpui_ack == 1'b0,     "reset_ack",   32'(cpui_ack), 32'h0);
        chk(cpui_rdata == 32'h0,  "reset_rdata", cpui_rdata, 32'h0);
        chk(mem_request == 1'b0,  "reset_mreq",  32'(mem_request), 32'h0);
        chk(mem_addr == 32'h0,    "reset_maddr", mem_addr, 32'h0);
        chk(busy == 1'b0,         "reset_busy",  32'(busy), 32'h0);
        rst_n = 1'b1;

        // Cold fetch, then consecutive hits on the same line.
        fetch(32'h100, -1, h);
        for (int k = 1; k < 4; k++) begin
            void'(model_access(32'h100 + 32'(4 * k)));
            exp_q.push_back(mem_word(32'h100 + 32'(4 * k)));
        end
        @(negedge clock);
        acks = 0;
        mreq_seen = 1'b0;
        for (int k = 1; k < 4; k++) begin
            cpui_request = 1'b1;
            cpui_addr    = 32'h100 + 32'(4 * k);
            @(negedge clock);
            acks += int'(cpui_ack);
            mreq_seen |= mem_request;
        end
        cpui_request = 1'b0;
        chk(acks == 3,          "b2b_acks", 32'(acks), 32'd3);
        chk(mreq_seen == 1'b0,  "b2b_no_refill", 32'(mreq_seen), 32'h0);

        // Invalidate during a refill: fetch completes, then a full flush.
        fetch(32'h200, 2, h);
        fetch(32'h200, -1, h);

        // Conflicting tags on one index.
        fetch(32'h100, -1, h);
        fetch(32'h1100, -1, h);
        fetch(32'h100, -1, h);
        fetch(32'h104, -1, h);

        // Reset in the middle of a refill after two words.
        ack_budget = 2;
        maddr_q.push_back(32'h300);
        maddr_q.push_back(32'h304);
        @(negedge clock);
        cpui_request = 1'b1;
        cpui_addr    = 32'h300;
        @(negedge clock);
        cpui_request = 1'b0;
        repeat (5) @(negedge clock);
        chk(mem_request == 1'b1, "refill_stalled", 32'(mem_request), 32'h1);
        chk(mem_addr == 32'h308, "stall_addr", mem_addr, 32'h308);
        rst_n = 1'b0;
        #1;
        chk(mem_request == 1'b0, "reset_drops_mreq", 32'(mem_request), 32'h0);
        chk(busy == 1'b0,        "reset_drops_busy", 32'(busy), 32'h0);
        @(negedge clock);
        rst_n      = 1'b1;
        ack_budget = -1;
        maddr_q.delete();
        model_invalidate();
        fetch(32'h300, -1, h);

        // Request and second invalidate during a flush.
        fetch(32'h104, -1, h);
        @(negedge clock);
        invalidate = 1'b1;
        @(negedge clock);
        invalidate = 1'b0;
        model_invalidate();
        void'(model_access(32'h104));
        exp_q.push_back(mem_word(32'h104));
        bc = 0;
        while (busy && bc < 400) begin
            bc++;
            cpui_request = (bc == 30);
            cpui_addr    = 32'h104;
            invalidate   = (bc == 20);
            @(negedge clock);
        end
        cpui_request = 1'b0;
        invalidate   = 1'b0;
        chk(bc == int'(NL), "flush_not_restarted", 32'(bc), 32'(NL));
        lat = 0;
        while (!cpui_ack && lat < 400) begin
            @(negedge clock);
            lat++;
        end
        chk(lat == int'(LW + 2), "post_flush_miss_latency", 32'(lat), 32'(LW + 2));

`ifdef ICACHE_STATS_EN
        do_flush();
        fetch(32'h2000, -1, h);
        for (int k = 1; k < 4; k++) fetch(32'h2000 + 32'(4 * k), -1, h);
        @(negedge clock);
        chk(hit_count == 32'd3,  "stats_hits",   hit_count, 32'd3);
        chk(miss_count == 32'd1, "stats_misses", miss_count, 32'd1);
        do_flush();
        chk(hit_count == 32'd0,  "stats_hits_cleared",   hit_count, 32'd0);
        chk(miss_count == 32'd0, "stats_misses_cleared", miss_count, 32'd0);
`endif

        // Random traffic with memory wait states.
        zero_wait = 1'b0;
        for (int n = 0; n < 160; n++) begin
            int unsigned r = $urandom_range(0, 19);
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2)  | 32'($urandom_range(0, 3));
            if (r == 0) do_flush();
            else        fetch(a, (r == 1) ? 0 : -1, h);
        end

        repeat (5) @(negedge clock);
        chk(exp_q.size() == 0,   "acks_outstanding",    32'(exp_q.size()), 32'h0);
        chk(maddr_q.size() == 0, "refills_outstanding", 32'(maddr_q.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end

endmodule
